seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit common-anode 7-segment display on the board.
- Sits directly upstream of the per-digit hex decoder. Each cycle it presents one 4-bit nibble and an enable to the decoder, and drives the active-low digit anodes itself.
- Holds a frame-synchronous copy of a 32-bit display word (e.g. PC or register value from the CPU), so the digits never tear mid-frame.
- Inserts a blanking gap between digits to prevent ghosting.

---
 rtl/seg7_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode display: per-digit ACTIVE/BLANK timing,
// frame-synchronous display word, leading-zero suppression. All outputs registered.
module seg7_scan_ctrl #(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        lz_sup,
  output logic [3:0]  nibble,
  output logic        seg_ena,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int unsigned MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int          CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [1:0] ST_BLANK  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   disp_q, disp_d;
  logic          pend_q, pend_d;
  logic [7:0]    an_q, an_d;
  logic          seg_ena_q, seg_ena_d;
  logic [3:0]    nibble_q, nibble_d;
  logic          fd_q, fd_d;
  logic          lit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    an_d      = an_q;
    seg_ena_d = seg_ena_q;
    nibble_d  = nibble_q;
    fd_d      = 1'b0;
    lit       = 1'b0;

    if (load) begin
      shadow_d = data_in;
      pend_d   = 1'b1;
    end

    case (state_q)
      ST_ACTIVE: begin
        if (cnt_q == CW'(DIV - 1)) begin
          state_d   = ST_BLANK;
          cnt_d     = '0;
          an_d      = 8'hFF;
          seg_ena_d = 1'b0;
          fd_d      = (idx_q == 3'd7);
        end
      end
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK_CYC - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          // Frame boundary: a load in this very cycle beats an older pending word.
          if (idx_q == 3'd7) begin
            if (load) begin
              disp_d = data_in;
              pend_d = 1'b0;
            end else if (pend_q) begin
              disp_d = shadow_q;
              pend_d = 1'b0;
            end
          end
          lit       = !(lz_sup && (idx_d != 3'd0) && ((disp_d >> {idx_d, 2'b00}) == 32'd0));
          nibble_d  = disp_d[{idx_d, 2'b00} +: 4];
          seg_ena_d = lit;
          an_d      = lit ? ~(8'd1 << idx_d) : 8'hFF;
        end
      end
      default: begin
        state_d   = ST_BLANK;
        cnt_d     = '0;
        an_d      = 8'hFF;
        seg_ena_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= 3'd7;
      shadow_q  <= '0;
      disp_q    <= '0;
      pend_q    <= 1'b0;
      an_q      <= 8'hFF;
      seg_ena_q <= 1'b0;
      nibble_q  <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      seg_ena_q <= seg_ena_d;
      nibble_q  <= nibble_d;
      fd_q      <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg_ena    = seg_ena_q;
  assign nibble     = nibble_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIV=4, BLANK_CYC=2 (48-cycle frame); expected per-cycle
// outputs are queued by cycle number and checked by an independent monitor.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic        lz_sup;
  logic [3:0]  nibble;
  logic        seg_ena;
  logic [7:0]  an;
  logic        frame_done;

  seg7_scan_ctrl #(.DIV(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .lz_sup     (lz_sup),
    .nibble     (nibble),
    .seg_ena    (seg_ena),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic       seg;
    logic [3:0] nib;
    logic       fd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0, t1;
  logic fin_req = 1'b0;
  logic fin_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame timeline: slot s = c/6; c%6 in {0,1} is BLANK, else digit s is ACTIVE.
  task automatic push_frame(input int base, input logic [31:0] disp, input logic [7:0] litm,
                            input logic [3:0] prev, input logic fd, input int ncyc);
    exp_t x;
    for (int c = 0; c < ncyc; c++) begin
      int slot;
      int pos;
      slot  = c / 6;
      pos   = c % 6;
      x.cyc = base + c;
      if (pos < 2) begin
        x.an  = 8'hFF;
        x.seg = 1'b0;
        x.nib = (slot == 0) ? prev : disp[4*(slot-1) +: 4];
        x.fd  = (c == 0) && fd;
      end else begin
        x.seg = litm[slot];
        x.an  = litm[slot] ? ~(8'd1 << slot) : 8'hFF;
        x.nib = disp[4*slot +: 4];
        x.fd  = 1'b0;
      end
      q.push_back(x);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(input logic [31:0] d);
    load    = 1'b1;
    data_in = d;
    @(posedge clk);
    #1;
    load    = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL stale_expect cyc=%0d never checked (now %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if ({an, seg_ena, nibble, frame_done} !== {e.an, e.seg, e.nib, e.fd}) begin
        errors++;
        $display("FAIL scan cyc=%0d got an=%h seg=%b nib=%h fd=%b expected an=%h seg=%b nib=%h fd=%b",
                 cyc - t0, an, seg_ena, nibble, frame_done, e.an, e.seg, e.nib, e.fd);
      end
    end
    if (fin_req && !fin_ack) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d entries left expected 0", q.size());
      end
      fin_ack = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = 32'h0;
    lz_sup  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    t0  = cyc;

    // Reset state and scan order with display 0.
    push_frame(t0, 32'h0, 8'hFF, 4'h0, 1'b0, 48);
    // Mid-frame load (digit 3) waits for the next frame.
    wait_to(t0 + 21);
    pulse_load(32'h89ABCDEF);
    push_frame(t0 + 48, 32'h89ABCDEF, 8'hFF, 4'h0, 1'b1, 48);
    // Last load wins.
    wait_to(t0 + 58);
    pulse_load(32'h11111111);
    wait_to(t0 + 78);
    pulse_load(32'h22222222);
    push_frame(t0 + 96, 32'h22222222, 8'hFF, 4'h8, 1'b1, 48);
    // Load on the boundary cycle itself takes effect at once.
    push_frame(t0 + 144, 32'h33333333, 8'hFF, 4'h2, 1'b1, 48);
    wait_to(t0 + 145);
    pulse_load(32'h33333333);
    // Leading-zero suppression.
    wait_to(t0 + 164);
    lz_sup = 1'b1;
    pulse_load(32'h00000A05);
    push_frame(t0 + 192, 32'h00000A05, 8'h07, 4'h3, 1'b1, 48);
    wait_to(t0 + 212);
    pulse_load(32'h0);
    push_frame(t0 + 240, 32'h0, 8'h01, 4'h0, 1'b1, 48);
    wait_to(t0 + 260);
    pulse_load(32'hFEDCBA98);
    wait_to(t0 + 287);
    lz_sup = 1'b0;
    // Reset during digit 5 with a pending load.
    push_frame(t0 + 288, 32'hFEDCBA98, 8'hFF, 4'h0, 1'b1, 34);
    wait_to(t0 + 298);
    pulse_load(32'h12345678);
    wait_to(t0 + 321);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t1  = cyc;
    push_frame(t1, 32'h0, 8'hFF, 4'h0, 1'b0, 48);
    wait_to(t1 + 48);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) @(posedge clk);
    if (!fin_ack) begin
      errors++;
      $display("FAIL monitor_done got no drain check expected one");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
